// File: rtl/pll_supervisor.sv
// Reset/lock supervisor for the pixel-clock PLL: pulses the PLL reset, qualifies lock,
// measures the pixel heartbeat against the reference clock and gates the pixel-domain reset.
module pll_supervisor #(
  parameter int unsigned RST_PULSE_CYC   = 16,
  parameter int unsigned LOCK_TIMEOUT    = 50000,
  parameter int unsigned LOCK_STABLE_CYC = 1024,
  parameter int unsigned WINDOW          = 16384,
  parameter int unsigned EXP_EDGES       = 645,
  parameter int unsigned TOL             = 8,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        pll_locked,
  input  logic        pix_hb,
  input  logic        restart,
  output logic        pll_rst,
  output logic        pix_rst_n,
  output logic        ready,
  output logic        fail,
  output logic [1:0]  retry_cnt,
  output logic [15:0] last_edges,
  output logic [2:0]  state
);

  localparam int unsigned MAX_A   = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
  localparam int unsigned MAX_B   = (LOCK_TIMEOUT > WINDOW) ? LOCK_TIMEOUT : WINDOW;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned EDGE_W  = 16;
  localparam int unsigned RETRY_W = 2;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_MEASURE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edges_q, edges_d, edges_sum, edge_dev;
  logic [EDGE_W-1:0]   last_edges_d;
  logic [RETRY_W-1:0]  retry_d;
  logic                lock_meta, lock_s;
  logic                hb_meta, hb_s, hb_prev;
  logic                hb_edge, in_tol, attempt_fail, terminal;

  // 2-FF synchronizers for the asynchronous lock and heartbeat inputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      hb_meta   <= 1'b0;
      hb_s      <= 1'b0;
      hb_prev   <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
      hb_meta   <= pix_hb;
      hb_s      <= hb_meta;
      hb_prev   <= hb_s;
    end
  end

  assign hb_edge = hb_s ^ hb_prev;

  // Next-state, counter and retry logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    edges_d      = edges_q;
    last_edges_d = last_edges;
    retry_d      = retry_cnt;
    attempt_fail = 1'b0;

    // an edge in the terminal cycle still belongs to the closing window
    edges_sum = (edges_q == {EDGE_W{1'b1}}) ? edges_q : edges_q + EDGE_W'(hb_edge);
    edge_dev  = (edges_sum > EDGE_W'(EXP_EDGES)) ? edges_sum - EDGE_W'(EXP_EDGES)
                                                 : EDGE_W'(EXP_EDGES) - edges_sum;
    in_tol    = (edge_dev <= EDGE_W'(TOL));
    terminal  = (cnt_q == CNT_W'(WINDOW - 1));

    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_PULSE_CYC - 1)) state_d = S_WAIT_LOCK;
        else                                    cnt_d   = cnt_q + CNT_W'(1);
      end
      S_WAIT_LOCK: begin
        if (lock_s)                                    state_d      = S_STABLE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))    attempt_fail = 1'b1;
        else                                           cnt_d        = cnt_q + CNT_W'(1);
      end
      S_STABLE: begin
        if (!lock_s)                                   state_d = S_WAIT_LOCK;
        else if (cnt_q == CNT_W'(LOCK_STABLE_CYC - 1)) state_d = S_MEASURE;
        else                                           cnt_d   = cnt_q + CNT_W'(1);
      end
      S_MEASURE, S_RUN: begin
        if (!lock_s) begin
          if (state_q == S_MEASURE) attempt_fail = 1'b1;
          else                      state_d      = S_RESET_PLL;
        end else if (terminal) begin
          last_edges_d = edges_sum;
          edges_d      = '0;
          cnt_d        = '0;
          if (in_tol) begin
            state_d = S_RUN;
            retry_d = '0;
          end else if (state_q == S_MEASURE) begin
            attempt_fail = 1'b1;
          end else begin
            state_d = S_RESET_PLL;
          end
        end else begin
          edges_d = edges_sum;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: state_d = S_RESET_PLL;
    endcase

    if (attempt_fail) begin
      if (retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
        state_d = S_FAIL;
        retry_d = RETRY_W'(MAX_RETRY);
      end else begin
        state_d = S_RESET_PLL;
        retry_d = retry_cnt + RETRY_W'(1);
      end
    end

    // every state starts its own count from zero
    if (state_d != state_q) begin
      cnt_d   = '0;
      edges_d = '0;
    end

    if (restart) begin
      state_d = S_RESET_PLL;
      retry_d = '0;
      cnt_d   = '0;
      edges_d = '0;
    end
  end

  // State register and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_RESET_PLL;
      cnt_q      <= '0;
      edges_q    <= '0;
      last_edges <= '0;
      retry_cnt  <= '0;
      pll_rst    <= 1'b1;
      pix_rst_n  <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edges_q    <= edges_d;
      last_edges <= last_edges_d;
      retry_cnt  <= retry_d;
      pll_rst    <= (state_d == S_RESET_PLL);
      pix_rst_n  <= (state_d == S_RUN);
      ready      <= (state_d == S_RUN);
      fail       <= (state_d == S_FAIL);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor: a PLL/heartbeat model drives the DUT, expected state
// visits are queued by the stimulus and checked by an independent transition monitor.
module tb_pll_supervisor;

  localparam int RST_PULSE_CYC   = 4;
  localparam int LOCK_TIMEOUT    = 100;
  localparam int LOCK_STABLE_CYC = 8;
  localparam int WINDOW          = 64;
  localparam int EXP_EDGES       = 40;
  localparam int TOL             = 2;
  localparam int MAX_RETRY       = 3;

  localparam int S_RESET = 0, S_WAIT = 1, S_STABLE = 2, S_MEAS = 3, S_RUN = 4, S_FAIL = 5;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        pll_locked = 1'b0;
  logic        pix_hb = 1'b0;
  logic        restart = 1'b0;
  logic        pll_rst, pix_rst_n, ready, fail;
  logic [1:0]  retry_cnt;
  logic [15:0] last_edges;
  logic [2:0]  state;

  pll_supervisor #(
    .RST_PULSE_CYC(RST_PULSE_CYC), .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
    .WINDOW(WINDOW), .EXP_EDGES(EXP_EDGES), .TOL(TOL), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .resetN(resetN), .pll_locked(pll_locked), .pix_hb(pix_hb), .restart(restart),
    .pll_rst(pll_rst), .pix_rst_n(pix_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .last_edges(last_edges), .state(state)
  );

  always #5 clk = ~clk;

  // expected state visit: state entered, retry count, last_edges (-1 = any), cycles spent in the state left (-1 = any)
  typedef struct { int st; int retry; int le; int dwell; } exp_t;
  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // heartbeat: exactly hb_n toggles in any WINDOW consecutive cycles
  int hb_n = 40;
  int hb_acc = 0;
  always @(negedge clk) begin
    hb_acc = hb_acc + hb_n;
    if (hb_acc >= WINDOW) begin
      hb_acc = hb_acc - WINDOW;
      pix_hb = ~pix_hb;
    end
  end

  // PLL model: loses lock under reset, relocks lock_delay cycles after reset release
  int lock_delay = 16;
  bit lock_en = 1'b1;
  bit lock_kill = 1'b0;
  int since_rst = 0;
  always @(negedge clk) begin
    if (pll_rst) since_rst = 0;
    else if (since_rst < 100000) since_rst = since_rst + 1;
    pll_locked = lock_en && !lock_kill && (since_rst >= lock_delay);
  end

  // Monitor: every change of state is popped against the scoreboard
  int prev_st = 0;
  int dwell = 0;
  always @(negedge clk) begin : monitor
    int st;
    exp_t e;
    bit bad;
    st = int'(state);
    dwell = dwell + 1;
    if (st != prev_st) begin
      vectors = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL unexpected_transition: state %0d -> %0d with no visit expected", prev_st, st);
      end else begin
        e = exp_q.pop_front();
        bad = (st != e.st) || (int'(retry_cnt) != e.retry) ||
              (fail != (e.st == S_FAIL)) || (ready != (e.st == S_RUN)) ||
              (pix_rst_n != (e.st == S_RUN)) || (pll_rst != (e.st == S_RESET)) ||
              (e.le >= 0 && int'(last_edges) != e.le) || (e.dwell >= 0 && dwell != e.dwell);
        if (bad) begin
          miscompares = miscompares + 1;
          $display("FAIL transition: got st=%0d retry=%0d fail=%0b ready=%0b pix_rst_n=%0b pll_rst=%0b last_edges=%0d dwell=%0d; expected st=%0d retry=%0d last_edges=%0d dwell=%0d",
                   st, retry_cnt, fail, ready, pix_rst_n, pll_rst, last_edges, dwell,
                   e.st, e.retry, e.le, e.dwell);
        end
      end
      prev_st = st;
      dwell = 0;
    end
    if (!resetN) dwell = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int got, int want);
    vectors = vectors + 1;
    if (got != want) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push(int st, int retry, int le, int dw);
    exp_t e;
    e.st = st; e.retry = retry; e.le = le; e.dwell = dw;
    exp_q.push_back(e);
  endtask

  function automatic bit edges_ok(int n);
    int d;
    d = n - EXP_EDGES;
    if (d < 0) d = -d;
    return d <= TOL;
  endfunction

  // Expected visits from RESET_PLL (retry 0) with a healthy PLL and hb_n edges per window
  task automatic expect_bringup(int n);
    for (int a = 0; a < MAX_RETRY; a++) begin
      push(S_WAIT, a, -1, RST_PULSE_CYC);
      push(S_STABLE, a, -1, -1);
      push(S_MEAS, a, -1, LOCK_STABLE_CYC);
      if (edges_ok(n)) begin
        push(S_RUN, 0, n, WINDOW);
        return;
      end
      if (a == MAX_RETRY - 1) push(S_FAIL, MAX_RETRY, n, WINDOW);
      else                    push(S_RESET, a + 1, n, WINDOW);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic wait_drain(string name, int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL %s: %0d expected visits still pending after %0d cycles (state %0d)",
               name, exp_q.size(), budget, state);
      exp_q.delete();
    end
  endtask

  task automatic wait_state(string name, int st, int budget);
    int k = 0;
    while (int'(state) != st && k < budget) begin
      tick();
      k++;
    end
    if (int'(state) != st) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL %s: state %0d, expected %0d within %0d cycles", name, state, st, budget);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_state"}, int'(state), S_RESET);
    check({tag, "_pll_rst"}, int'(pll_rst), 1);
    check({tag, "_pix_rst_n"}, int'(pix_rst_n), 0);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_fail"}, int'(fail), 0);
    check({tag, "_retry"}, int'(retry_cnt), 0);
    check({tag, "_last_edges"}, int'(last_edges), 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    #1 resetN = 1'b0;
    #1;
    check_reset_outputs("por");

    // nominal bring-up, lock at ~cycle 20, 40 edges per window
    repeat (3) @(posedge clk);
    expect_bringup(40);
    @(negedge clk);
    #2 resetN = 1'b1;
    wait_drain("nominal", 400);
    repeat (WINDOW + 4) tick();
    check("run_repeat_state", int'(state), S_RUN);
    check("run_repeat_last_edges", int'(last_edges), 40);

    // one-cycle lock glitch in STABLE: back to WAIT_LOCK without a retry
    push(S_RESET, 0, -1, -1);
    push(S_WAIT, 0, -1, RST_PULSE_CYC);
    push(S_STABLE, 0, -1, -1);
    push(S_WAIT, 0, -1, -1);
    push(S_STABLE, 0, -1, -1);
    push(S_MEAS, 0, -1, LOCK_STABLE_CYC);
    push(S_RUN, 0, 40, WINDOW);
    pulse_restart();
    wait_state("glitch_reach_stable", S_STABLE, 200);
    tick();
    lock_kill = 1'b1;
    tick();
    lock_kill = 1'b0;
    wait_drain("glitch", 400);

    // frequency fault: 43 edges exhausts retries
    hb_n = 43;
    push(S_RESET, 0, -1, -1);
    expect_bringup(43);
    pulse_restart();
    wait_drain("freq_fault", 1200);
    check("fault_state", int'(state), S_FAIL);
    check("fault_fail", int'(fail), 1);
    check("fault_retry", int'(retry_cnt), MAX_RETRY);
    check("fault_pll_rst", int'(pll_rst), 0);

    // lower tolerance boundary still runs
    hb_n = 38;
    push(S_RESET, 0, -1, -1);
    expect_bringup(38);
    pulse_restart();
    wait_drain("boundary_38", 400);
    check("boundary_ready", int'(ready), 1);

    // lock timeout on every attempt
    lock_en = 1'b0;
    push(S_RESET, 0, -1, -1);
    for (int a = 0; a < MAX_RETRY; a++) begin
      push(S_WAIT, a, -1, RST_PULSE_CYC);
      if (a == MAX_RETRY - 1) push(S_FAIL, MAX_RETRY, -1, LOCK_TIMEOUT);
      else                    push(S_RESET, a + 1, -1, LOCK_TIMEOUT);
    end
    pulse_restart();
    wait_drain("timeout", 600);
    lock_en = 1'b1;
    hb_n = 40;
    push(S_RESET, 0, -1, -1);
    expect_bringup(40);
    pulse_restart();
    check("restart_state", int'(state), S_RESET);
    check("restart_fail", int'(fail), 0);
    check("restart_retry", int'(retry_cnt), 0);
    check("restart_pll_rst", int'(pll_rst), 1);
    wait_drain("after_timeout", 400);

    // randomized edge rates and lock delays
    for (int t = 0; t < 6; t++) begin
      hb_n = int'($urandom_range(45, 35));
      lock_delay = int'($urandom_range(40, 3));
      push(S_RESET, 0, -1, -1);
      expect_bringup(hb_n);
      pulse_restart();
      wait_drain("random_trial", 1500);
      check("random_final_state", int'(state), edges_ok(hb_n) ? S_RUN : S_FAIL);
    end

    // loss of lock while running
    hb_n = 40;
    lock_delay = 12;
    push(S_RESET, 0, -1, -1);
    expect_bringup(40);
    pulse_restart();
    wait_drain("pre_loss", 400);
    push(S_RESET, 0, -1, -1);
    expect_bringup(40);
    lock_kill = 1'b1;
    k = 0;
    while (ready && k < 10) begin
      tick();
      k++;
    end
    check("loss_latency_cycles", k, 3);
    check("loss_pix_rst_n", int'(pix_rst_n), 0);
    check("loss_state", int'(state), S_RESET);
    check("loss_retry", int'(retry_cnt), 0);
    lock_kill = 1'b0;
    wait_drain("relock", 400);

    // asynchronous reset in the middle of MEASURE
    push(S_RESET, 0, -1, -1);
    push(S_WAIT, 0, -1, RST_PULSE_CYC);
    push(S_STABLE, 0, -1, -1);
    push(S_MEAS, 0, -1, LOCK_STABLE_CYC);
    push(S_RESET, 0, 0, -1);
    pulse_restart();
    wait_state("reach_measure", S_MEAS, 200);
    repeat (10) tick();
    #2 resetN = 1'b0;
    #1;
    check_reset_outputs("mid_measure");
    wait_drain("mid_measure_reset", 20);
    expect_bringup(40);
    @(negedge clk);
    #2 resetN = 1'b1;
    wait_drain("post_reset", 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
